// File: rtl/aes_shiftmix_col.sv
// aes_shiftmix_col
// ----------------
// Collects the four SubBytes output columns of one AES state (column 0
// first), then emits the ShiftRows + MixColumns result one column per
// accepted output handshake. MixColumns is skipped when the state was
// flagged as the final round (in_last sampled with column 0).
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     upstream column valid
//   in_ready     high while the state buffer is filling
//   in_col       SubBytes column, [31:24]=row 0 ... [7:0]=row 3
//   in_last      final-round flag, taken only with column 0
//   out_valid    result column valid
//   out_ready    downstream accepts the presented column
//   out_col      result column (0 while out_valid is low)
//   out_idx      index of the presented column
//   busy         high whenever the buffer holds data
//
// Optional build macro AES_SHIFTMIX_OREG_EN: registers out_col/out_idx,
// adding one cycle before the first result of each state.

module aes_shiftmix_col #(
  parameter int NCOL = 4   // columns per state; only 4 is meaningful
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic [1:0]  out_idx,
  output logic        busy
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  in_cnt_q, in_cnt_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic        last_q, last_d;
  logic [31:0] st_q [NCOL];

  logic        in_fire;
  logic        out_fire;
  logic [1:0]  sel_idx;
  logic [1:0]  sel_p1, sel_p2, sel_p3;
  logic [7:0]  a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] result;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] v);
    return xtime(v) ^ v;
  endfunction

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign busy     = (state_q == DRAIN) || (in_cnt_q != 2'd0);

  // ShiftRows picks row r of the shifted column c from buffered column
  // (c+r) mod 4; the 2-bit index arithmetic gives the wrap for free.
  assign sel_p1 = sel_idx + 2'd1;
  assign sel_p2 = sel_idx + 2'd2;
  assign sel_p3 = sel_idx + 2'd3;
  assign a0 = st_q[sel_idx][31:24];
  assign a1 = st_q[sel_p1][23:16];
  assign a2 = st_q[sel_p2][15:8];
  assign a3 = st_q[sel_p3][7:0];

  assign b0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
  assign b1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
  assign b2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
  assign b3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);

  assign result = last_q ? {a0, a1, a2, a3} : {b0, b1, b2, b3};

  // Next-state logic: fill four columns, then drain four results.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    last_d    = last_q;
    in_ready  = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_cnt_d = in_cnt_q + 2'd1;
          if (in_cnt_q == 2'd0) last_d = in_last;
          if (in_cnt_q == 2'd3) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          out_cnt_d = out_cnt_q + 2'd1;
          if (out_cnt_q == 2'd3) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      in_cnt_q  <= 2'd0;
      out_cnt_q <= 2'd0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      last_q    <= last_d;
    end
  end

  // State buffer; contents after reset are irrelevant, so no reset here.
  always_ff @(posedge clk) begin
    if (in_fire) st_q[in_cnt_q] <= in_col;
  end

`ifdef AES_SHIFTMIX_OREG_EN
  logic        oval_q, oval_d;
  logic [31:0] ocol_q, ocol_d;
  logic [1:0]  oidx_q, oidx_d;

  // Once the register is presenting column n, the datapath already
  // computes column n+1 so it can be loaded on the accepting edge.
  assign sel_idx = oval_q ? out_cnt_q + 2'd1 : out_cnt_q;

  // Output register: first load on entry to DRAIN, reload after each
  // accepted column, clear after the last one.
  always_comb begin
    oval_d = oval_q;
    ocol_d = ocol_q;
    oidx_d = oidx_q;
    if (state_q == DRAIN) begin
      if (!oval_q) begin
        oval_d = 1'b1;
        ocol_d = result;
        oidx_d = sel_idx;
      end else if (out_fire) begin
        if (out_cnt_q == 2'd3) begin
          oval_d = 1'b0;
          ocol_d = 32'h0;
          oidx_d = 2'd0;
        end else begin
          ocol_d = result;
          oidx_d = sel_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oval_q <= 1'b0;
      ocol_q <= 32'h0;
      oidx_q <= 2'd0;
    end else begin
      oval_q <= oval_d;
      ocol_q <= ocol_d;
      oidx_q <= oidx_d;
    end
  end

  assign out_valid = oval_q;
  assign out_col   = ocol_q;
  assign out_idx   = oidx_q;
`else
  assign sel_idx   = out_cnt_q;
  assign out_valid = (state_q == DRAIN);
  assign out_col   = out_valid ? result : 32'h0;
  assign out_idx   = out_cnt_q;
`endif

endmodule

// File: tb/tb_aes_shiftmix_col.sv
// Testbench for aes_shiftmix_col: FIPS-197 vectors, final round, stall,
// mid-drain reset, upstream gaps and randomized states, all compared on
// every cycle against a byte-matrix reference model.

module tb_aes_shiftmix_col;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_col;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_col;
  logic [1:0]  out_idx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

`ifdef AES_SHIFTMIX_OREG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_shiftmix_col #(.NCOL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  // Reference model state: phase 0 = filling, 1 = output register load
  // (registered-output build only), 2 = draining.
  int          mPhase;
  int          mInCnt;
  int          mOutCnt;
  logic        mLast;
  logic [31:0] mCols [4];
  logic [31:0] mExp [4];
  logic        mFill;
  logic        mDrain;
  bit          monOn = 1'b0;
  logic [31:0] gotQ [$];

  logic [31:0] fips   [4] = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
  logic [31:0] r1Exp  [4] = '{32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
  logic [31:0] finExp [4] = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
  logic [31:0] single [4] = '{32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345};

  // General GF(2^8) product: carry-less multiply, then reduce by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Whole-state reference: byte matrix, ShiftRows, then the MixColumns
  // matrix product unless this is the final round.
  function automatic void modelState(input logic [31:0] cols [4], input logic last,
                                     output logic [31:0] res [4]);
    logic [7:0] s  [4][4];
    logic [7:0] sh [4][4];
    logic [7:0] coef [4][4];
    logic [7:0] acc;
    coef = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
             '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = cols[c][31 - 8*r -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sh[r][c] = s[r][(c + r) % 4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (last) begin
          acc = sh[r][c];
        end else begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[r][k], sh[k][c]);
        end
        res[c][31 - 8*r -: 8] = acc;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    mPhase  = 0;
    mInCnt  = 0;
    mOutCnt = 0;
    mLast   = 1'b0;
  endtask

  // Compare process: checks every output against the model each cycle,
  // then advances the model with the handshakes of the coming edge.
  always @(negedge clk) begin
    if (monOn) begin
      mFill  = (mPhase == 0);
      mDrain = (mPhase == 2);
      checkOutput("in_ready", 32'(in_ready), 32'(mFill));
      checkOutput("out_valid", 32'(out_valid), 32'(mDrain));
      checkOutput("busy", 32'(busy), 32'(!(mFill && mInCnt == 0)));
      checkOutput("out_col", out_col, mDrain ? mExp[mOutCnt] : 32'h0);
      checkOutput("out_idx", 32'(out_idx), mDrain ? mOutCnt : 0);
      if (rst) begin
        modelReset();
      end else if (mPhase == 0) begin
        if (in_valid) begin
          mCols[mInCnt] = in_col;
          if (mInCnt == 0) mLast = in_last;
          mInCnt++;
          if (mInCnt == 4) begin
            modelState(mCols, mLast, mExp);
            mInCnt  = 0;
            mOutCnt = 0;
            mPhase  = OREG ? 1 : 2;
          end
        end
      end else if (mPhase == 1) begin
        mPhase = 2;
      end else begin
        if (out_ready) begin
          gotQ.push_back(out_col);
          mOutCnt++;
          if (mOutCnt == 4) begin
            mOutCnt = 0;
            mPhase  = 0;
          end
        end
      end
    end
  end

  // Drives one state through the block. vPct < 0 selects the fixed
  // in_valid gap pattern 1,0,1,0,1,1. stallLen holds out_ready low while
  // column 1 is presented; abortAt > 0 pulses rst after that many outputs.
  task automatic applyStimulus(input logic [31:0] cols [4], input logic last,
                               input int vPct, input int rPct,
                               input int stallLen, input int abortAt);
    int sent    = 0;
    int cyc     = 0;
    int stalled = 0;
    int base    = gotQ.size();
    bit acc;
    bit stall;
    bit gapPat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    while (gotQ.size() - base < 4) begin
      if (abortAt > 0 && gotQ.size() - base == abortAt) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        return;
      end
      if (cyc >= 300) begin
        checks++;
        failures++;
        $display("[TB] FAIL timeout outputs got=%0d expected=4", gotQ.size() - base);
        in_valid = 1'b0; out_ready = 1'b0;
        return;
      end
      if (sent < 4) begin
        if (vPct < 0) in_valid = (cyc < 6) ? gapPat[cyc] : 1'b0;
        else          in_valid = int'($urandom_range(99)) < vPct;
        in_col = cols[sent];
      end else begin
        in_valid = 1'($urandom_range(1));
        in_col   = $urandom;
      end
      in_last   = (sent == 0) ? last : 1'($urandom_range(1));
      stall     = (stallLen > 0) && (gotQ.size() - base == 1) && (stalled < stallLen);
      out_ready = stall ? 1'b0 : (int'($urandom_range(99)) < rPct);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (stall) begin
        stalled++;
        checkOutput("stall_out_col", out_col, 32'he0cb199a);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (stallLen > 0) checkOutput("stall_cycles", 32'(stalled), 32'(stallLen));
    if (vPct < 0) checkOutput("gap_columns_taken", 32'(sent), 32'd4);
  endtask

  task automatic checkLiteral(input string name, input int base, input logic [31:0] exp [4]);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_col%0d", name, i),
                  (base + i < gotQ.size()) ? gotQ[base + i] : 32'hxxxxxxxx, exp[i]);
  endtask

  initial begin
    logic [31:0] res [4];
    logic [31:0] rcols [4];
    int base;

    rst = 1'b1; in_valid = 1'b0; in_col = 32'h0; in_last = 1'b0; out_ready = 1'b0;
    modelReset();

    // Pin the reference model to the published vectors.
    modelState(fips, 1'b0, res);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("model_r1_%0d", i), res[i], r1Exp[i]);
    modelState(fips, 1'b1, res);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("model_fin_%0d", i), res[i], finExp[i]);
    modelState(single, 1'b0, res);
    checkOutput("model_single", res[0], 32'h8e4da1bc);

    @(posedge clk); #1;
    monOn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_col", out_col, 32'h0);
    checkOutput("reset_out_idx", 32'(out_idx), 32'd0);
    @(posedge clk); #1;

    $display("[TB] round 1 vector");
    base = gotQ.size();
    applyStimulus(fips, 1'b0, 100, 100, 0, 0);
    checkLiteral("round1", base, r1Exp);

    $display("[TB] final round vector");
    base = gotQ.size();
    applyStimulus(fips, 1'b1, 100, 100, 0, 0);
    checkLiteral("final", base, finExp);

    $display("[TB] backpressure on column 1");
    base = gotQ.size();
    applyStimulus(fips, 1'b0, 100, 100, 5, 0);
    checkLiteral("stall", base, r1Exp);

    $display("[TB] single column vector");
    base = gotQ.size();
    applyStimulus(single, 1'b0, 100, 100, 0, 0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("single_col%0d", i), gotQ[base + i], 32'h8e4da1bc);

    $display("[TB] reset mid-drain");
    applyStimulus(fips, 1'b0, 100, 100, 0, 2);
    base = gotQ.size();
    applyStimulus(fips, 1'b0, 100, 100, 0, 0);
    checkLiteral("after_reset", base, r1Exp);

    $display("[TB] upstream gaps");
    base = gotQ.size();
    applyStimulus(fips, 1'b0, -1, 100, 0, 0);
    checkLiteral("gaps", base, r1Exp);

    $display("[TB] randomized states");
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) rcols[i] = $urandom;
      applyStimulus(rcols, 1'($urandom_range(1)), 40 + int'($urandom_range(60)),
                    30 + int'($urandom_range(70)), 0, 0);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
